// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Purpose:
//   Iterative RV64M multiply/divide unit. Multiplies use radix-2 shift-add,
//   divides use radix-2 restoring division, one step per clock (64 steps).
//   Operands are converted to unsigned magnitudes at capture time, and the
//   sign is re-applied when the result is written. Division by zero and
//   signed overflow are resolved at capture and skip the iterative phase.
//
// Optional feature:
//   MULDIV_FAST_MUL_EN - when defined, multiplies (funct3 0-3) use a
//   single-cycle full-width multiplier and go straight to DONE. Divides stay
//   iterative. Results are identical in both builds.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   synchronous active-low reset
//   start     in   1   operation request, only sampled in IDLE
//   funct3    in   3   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU,
//                      6 REM, 7 REMU
//   word      in   1   W variant (32-bit operands, sign-extended result)
//   op1_data  in  64   rs1
//   op2_data  in  64   rs2
//   flush     in   1   abort the operation in progress
//   busy      out  1   operation in progress (CALC or DONE)
//   valid     out  1   one-cycle result strobe
//   result    out 64   final result, held until the next valid
// ---------------------------------------------------------------------------
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic        word,
    input  logic [63:0] op1_data,
    input  logic [63:0] op2_data,
    input  logic        flush,
    output logic        busy,
    output logic        valid,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [2:0]   funct3_q;
    logic         word_q;
    logic         neg_q;
    logic         special_q;
    logic [63:0]  divisor_q;
    logic [127:0] prod_q;
    logic [5:0]   cnt_q;

    // ---------------- capture-side decode ----------------
    logic         is_div;
    logic         signed_a;
    logic         signed_b;
    logic [63:0]  a_ext;
    logic [63:0]  b_ext;
    logic         sign_a;
    logic         sign_b;
    logic [63:0]  a_mag;
    logic [63:0]  b_mag;
    logic         neg_in;
    logic         div_zero;
    logic         div_ovf;
    logic         special_in;
    logic [63:0]  dividend_sx;
    logic [63:0]  special_val;

    always_comb begin
        is_div   = funct3[2];
        signed_a = (funct3 == 3'd1) || (funct3 == 3'd2) ||
                   (funct3 == 3'd4) || (funct3 == 3'd6);
        signed_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);

        if (word) begin
            a_ext = signed_a ? {{32{op1_data[31]}}, op1_data[31:0]}
                             : {32'd0, op1_data[31:0]};
            b_ext = signed_b ? {{32{op2_data[31]}}, op2_data[31:0]}
                             : {32'd0, op2_data[31:0]};
        end else begin
            a_ext = op1_data;
            b_ext = op2_data;
        end

        sign_a = signed_a & a_ext[63];
        sign_b = signed_b & b_ext[63];
        // The most negative value negates to itself, which is still the
        // correct unsigned magnitude (2^63).
        a_mag  = sign_a ? (~a_ext + 64'd1) : a_ext;
        b_mag  = sign_b ? (~b_ext + 64'd1) : b_ext;

        // Remainders follow the dividend sign, everything else the xor.
        if (is_div && funct3[1])
            neg_in = sign_a;
        else
            neg_in = sign_a ^ sign_b;

        dividend_sx = word ? {{32{op1_data[31]}}, op1_data[31:0]} : op1_data;

        div_zero = is_div && (word ? (op2_data[31:0] == 32'd0)
                                   : (op2_data == 64'd0));
        div_ovf  = is_div && !funct3[0] &&
                   (word ? ((op1_data[31:0] == 32'h8000_0000) &&
                            (op2_data[31:0] == 32'hFFFF_FFFF))
                         : ((op1_data == 64'h8000_0000_0000_0000) &&
                            (op2_data == 64'hFFFF_FFFF_FFFF_FFFF)));
        special_in = div_zero || div_ovf;

        if (div_zero)
            special_val = funct3[1] ? dividend_sx : 64'hFFFF_FFFF_FFFF_FFFF;
        else
            special_val = funct3[1] ? 64'd0 : dividend_sx;
    end

    // ---------------- one radix-2 step ----------------
    // Multiply keeps {accumulator, multiplier} in prod_q and shifts right.
    // Divide keeps {remainder, quotient/dividend} and shifts left.
    logic [64:0]  mul_sum;
    logic [64:0]  div_shift;
    logic [64:0]  div_diff;
    logic [127:0] step_next;

    always_comb begin
        mul_sum   = prod_q[0] ? ({1'b0, prod_q[127:64]} + {1'b0, divisor_q})
                              : {1'b0, prod_q[127:64]};
        div_shift = prod_q[127:63];
        div_diff  = div_shift - {1'b0, divisor_q};
        if (funct3_q[2]) begin
            if (!div_diff[64])
                step_next = {div_diff[63:0], prod_q[62:0], 1'b1};
            else
                step_next = {div_shift[63:0], prod_q[62:0], 1'b0};
        end else begin
            step_next = {mul_sum, prod_q[63:1]};
        end
    end

    // ---------------- final result formatting ----------------
    logic [127:0] mul_fixed;
    logic [63:0]  mul_sel;
    logic [63:0]  div_raw;
    logic [63:0]  div_sel;
    logic [63:0]  sel;
    logic [63:0]  final_res;

    always_comb begin
        mul_fixed = neg_q ? (~prod_q + 128'd1) : prod_q;
        mul_sel   = (funct3_q == 3'd0) ? mul_fixed[63:0] : mul_fixed[127:64];
        div_raw   = funct3_q[1] ? prod_q[127:64] : prod_q[63:0];
        div_sel   = neg_q ? (~div_raw + 64'd1) : div_raw;
        sel       = funct3_q[2] ? div_sel : mul_sel;
        final_res = word_q ? {{32{sel[31]}}, sel[31:0]} : sel;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (special_in)
                        next_state = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    else if (!funct3[2])
                        next_state = DONE;
`endif
                    else
                        next_state = CALC;
                end
            end
            CALC: begin
                if (flush)
                    next_state = IDLE;
                else if (cnt_q == 6'd63)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ---------------- datapath ----------------
    // valid is registered in DONE, so it is seen the cycle after DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            funct3_q  <= 3'd0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            divisor_q <= 64'd0;
            prod_q    <= 128'd0;
            cnt_q     <= 6'd0;
            valid     <= 1'b0;
            result    <= 64'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        funct3_q  <= funct3;
                        word_q    <= word;
                        neg_q     <= neg_in;
                        special_q <= special_in;
                        cnt_q     <= 6'd0;
                        divisor_q <= is_div ? b_mag : a_mag;
                        if (special_in)
                            prod_q <= {64'd0, special_val};
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div)
                            prod_q <= {64'd0, a_mag} * {64'd0, b_mag};
`endif
                        else
                            prod_q <= {64'd0, is_div ? a_mag : b_mag};
                    end
                end
                CALC: begin
                    if (!flush) begin
                        prod_q <= step_next;
                        cnt_q  <= cnt_q + 6'd1;
                    end
                end
                DONE: begin
                    if (!flush) begin
                        valid  <= 1'b1;
                        result <= special_q ? prod_q[63:0] : final_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
